// File: rtl/pdm_pkg.sv
// Shared constants, accumulator type, FSM states and output saturation helper
// for the PDM-to-PCM CIC receiver.
package pdm_pkg;

  localparam int unsigned CIC_ORDER = 3;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned RMAX      = 256;
  localparam int unsigned WIDE_W    = 2 * ACC_W;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp a widened, shifted comb result into the signed accumulator range.
  function automatic acc_t sat_acc(input logic signed [WIDE_W-1:0] v);
    if (v > WIDE_W'(ACC_MAX)) begin
      return ACC_MAX;
    end else if (v < WIDE_W'(ACC_MIN)) begin
      return ACC_MIN;
    end
    return v[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/pdm_edge_sync.sv
// Two-flop synchronizer for a slow asynchronous clock-like input, followed by
// a rising-edge detector that produces a single-clk pulse.
module pdm_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic pulse_c
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign pulse_c = sync_q[1] & ~prev_q;

endmodule

// File: rtl/pdm_cic_rx.sv
// Third-order CIC decimator turning a 1-bit PDM stream into PCM samples.
// Define PDM_CIC_RX_OVF_EN to add the sticky decimation-ratio overflow flag ovf.
module pdm_cic_rx
  import pdm_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        sdi,
  input  logic        ock,
  input  logic        uck,
  input  logic        signed_data,
  input  logic [4:0]  shift,
  output logic [31:0] dout,
  output logic        dout_vld
`ifdef PDM_CIC_RX_OVF_EN
  ,
  output logic        ovf
`endif
);

  logic       ock_p;
  logic       uck_p;
  logic [1:0] sdi_q;

  acc_t integ_q [CIC_ORDER];
  acc_t integ_d [CIC_ORDER];
  acc_t dly_q   [CIC_ORDER];
  acc_t dly_d   [CIC_ORDER];
  acc_t comb_y;
  acc_t sat_s;
  logic signed [WIDE_W-1:0] scaled;
  logic [ACC_W-1:0] dout_d;

  state_e     state_q;
  logic [1:0] fill_cnt_q;
  logic [ACC_W-1:0] dout_q;
  logic       dout_vld_q;

  pdm_edge_sync u_ock_sync (
    .clk     (clk),
    .rstn    (rstn),
    .d_i     (ock),
    .pulse_c (ock_p)
  );

  pdm_edge_sync u_uck_sync (
    .clk     (clk),
    .rstn    (rstn),
    .d_i     (uck),
    .pulse_c (uck_p)
  );

  // Integrate first so a coincident comb sees the post-update I3.
  always_comb begin
    integ_d = integ_q;
    if (ock_p) begin
      integ_d[0] = integ_q[0] + (sdi_q[1] ? acc_t'(1) : acc_t'(-1));
      for (int unsigned k = 1; k < CIC_ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_d[k-1];
      end
    end
    comb_y = integ_d[CIC_ORDER-1];
    for (int unsigned k = 0; k < CIC_ORDER; k++) begin
      dly_d[k] = comb_y;
      comb_y   = comb_y - dly_q[k];
    end
    scaled = WIDE_W'(comb_y) <<< shift;
    sat_s  = sat_acc(scaled);
    dout_d = signed_data ? sat_s : {~sat_s[ACC_W-1], sat_s[ACC_W-2:0]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdi_q <= 2'b00;
      for (int unsigned k = 0; k < CIC_ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
    end else begin
      sdi_q   <= {sdi_q[0], sdi};
      integ_q <= integ_d;
      if (uck_p) begin
        dly_q <= dly_d;
      end
    end
  end

  // FILL waits out three decimation periods so the comb delays hold real history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= 2'd0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (uck_p) begin
            fill_cnt_q <= fill_cnt_q + 2'd1;
            if (fill_cnt_q == 2'd2) begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (uck_p) begin
            dout_q     <= dout_d;
            dout_vld_q <= 1'b1;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

`ifdef PDM_CIC_RX_OVF_EN
  logic [8:0] ock_cnt_q;
  logic       ovf_q;

  // Counts bit clocks per output period; saturates so it never wraps back under RMAX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ock_cnt_q <= 9'd0;
      ovf_q     <= 1'b0;
    end else begin
      if (uck_p) begin
        ock_cnt_q <= 9'd0;
      end else if (ock_p && (ock_cnt_q != 9'h1FF)) begin
        ock_cnt_q <= ock_cnt_q + 9'd1;
      end
      if (ock_cnt_q > 9'(RMAX)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pdm_cic_rx.sv
// Scoreboard bench for pdm_cic_rx: expected PCM words are pushed when uck rises
// and popped when dout_vld fires.
module tb_pdm_cic_rx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sdi;
  logic        ock;
  logic        uck;
  logic        signed_data;
  logic [4:0]  shift;
  logic [31:0] dout;
  logic        dout_vld;
`ifdef PDM_CIC_RX_OVF_EN
  logic        ovf;
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          pattern = 0;
  int          uck_n = 0;
  bit          sb_en = 1'b1;
  bit          alt_q = 1'b0;
  bit          glitch_en = 1'b0;

  pdm_cic_rx dut (
    .clk         (clk),
    .rstn        (rstn),
    .sdi         (sdi),
    .ock         (ock),
    .uck         (uck),
    .signed_data (signed_data),
    .shift       (shift),
    .dout        (dout),
    .dout_vld    (dout_vld)
`ifdef PDM_CIC_RX_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Steady-state CIC output: |y3| = R^3 for constant input, 0 for alternating.
  function automatic logic [31:0] cic_expect(input int r, input int pat, input int sh, input bit sgn);
    longint y;
    longint s;
    logic [31:0] v;
    if (pat == 0)      y = longint'(r) * r * r;
    else if (pat == 1) y = -(longint'(r) * r * r);
    else               y = 0;
    s = y <<< sh;
    if (s > 64'sh7FFFFFFF)       v = 32'h7FFFFFFF;
    else if (s < -64'sh80000000) v = 32'h80000000;
    else                         v = s[31:0];
    return sgn ? v : (v ^ 32'h80000000);
  endfunction

  always @(negedge clk) begin
    if (rstn && sb_en && dout_vld) begin
      if (exp_q.size() == 0) chk("spurious_vld", {31'b0, dout_vld}, 32'd0);
      else                   chk("dout", dout, exp_q.pop_front());
    end
  end

  task automatic ock_period();
    case (pattern)
      0: sdi = 1'b1;
      1: sdi = 1'b0;
      default: begin sdi = alt_q; alt_q = ~alt_q; end
    endcase
    repeat (2) @(posedge clk);
    ock = 1'b1;
    repeat (4) @(posedge clk);
    ock = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic uck_period(input int r);
    logic [4:0] keep;
    keep = shift;
    uck = 1'b1;
    uck_n++;
    if (sb_en && uck_n >= 4) exp_q.push_back(cic_expect(r, pattern, int'(shift), signed_data));
    for (int i = 0; i < r; i++) begin
      if (i == r / 2) uck = 1'b0;
      if (glitch_en && i == r / 4) shift = 5'd0;
      if (glitch_en && i == (3 * r) / 4) shift = keep;
      ock_period();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ock = 1'b0;
    uck = 1'b0;
    sdi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'd0);
    chk("rst_vld", {31'b0, dout_vld}, 32'd0);
`ifdef PDM_CIC_RX_OVF_EN
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    uck_n = 0;
    alt_q = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    sdi = 1'b0;
    ock = 1'b0;
    uck = 1'b0;
    signed_data = 1'b1;
    shift = 5'd7;

    // All ones, R=16; a shift change between uck edges must not leak through.
    do_reset();
    pattern = 0;
    repeat (4) uck_period(16);
    glitch_en = 1'b1;
    uck_period(16);
    glitch_en = 1'b0;
    repeat (2) uck_period(16);
    drain();

    // All zeros, signed then offset-binary.
    do_reset();
    pattern = 1;
    repeat (5) uck_period(16);
    signed_data = 1'b0;
    repeat (2) uck_period(16);
    drain();

    // Alternating bits cancel at Nyquist.
    do_reset();
    pattern = 2;
    repeat (6) uck_period(16);
    drain();

    // R=256 saturates at shift 7 and fits at shift 6.
    do_reset();
    pattern = 0;
    signed_data = 1'b1;
    shift = 5'd7;
    repeat (5) uck_period(256);
    shift = 5'd6;
    repeat (2) uck_period(256);
    drain();
`ifdef PDM_CIC_RX_OVF_EN
    chk("ovf_r256", {31'b0, ovf}, 32'd0);
`endif

    // Asynchronous reset mid-run, then a full refill.
    do_reset();
    shift = 5'd7;
    repeat (5) uck_period(16);
    drain();
    chk("pre_rst_dout", dout, 32'h00080000);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_dout", dout, 32'd0);
    chk("async_vld", {31'b0, dout_vld}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    uck_n = 0;
    repeat (6) uck_period(16);
    drain();

`ifdef PDM_CIC_RX_OVF_EN
    // Over-long decimation period sets the sticky flag.
    do_reset();
    sb_en = 1'b0;
    uck_period(300);
    repeat (3) uck_period(16);
    chk("ovf_set", {31'b0, ovf}, 32'd1);
    repeat (2) uck_period(16);
    chk("ovf_sticky", {31'b0, ovf}, 32'd1);
    sb_en = 1'b1;
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_cic_rx.md
PDM_CIC_RX -- requirements
Module: pdm_cic_rx

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk in, rstn in.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 sdi  input  1  PDM bitstream; 1 means +1, 0 means -1.
REQ-005 ock  input  1  PDM bit clock; slow square wave, asynchronous to clk.
REQ-006 uck  input  1  PCM output-rate clock; slow square wave, asynchronous to clk.
REQ-007 signed_data  input  1  1 selects two's-complement dout; 0 selects offset-binary dout.
REQ-008 shift  input  5  left-shift gain applied to the comb output.
REQ-009 dout  output  32  PCM sample.
REQ-010 dout_vld  output  1  one-clk pulse marking a new dout.

Function
REQ-011 SHALL pass ock and uck through a 2-flop synchronizer, then rising-edge detect them; the result is one clk pulse per edge (ock_p, uck_p).
REQ-012 On ock_p, SHALL sample sdi (through the same 2-flop delay) and apply it as +1 or -1 to integrator I1.
REQ-013 SHALL form a 3-stage integrator chain, I1 -> I2 -> I3, each 32 bits, two's complement, with modulo-2^32 wrap and no saturation; all three stages update in the same clk on ock_p.
REQ-014 On uck_p, SHALL run a 3-stage comb at decimation rate: each stage computes y_k = x_k - d_k, then d_k <= x_k, with x_1 = I3; all arithmetic is 32-bit modulo.
REQ-015 When ock_p and uck_p occur in the same clk, the comb SHALL use the post-update integrator value (integrate first, then comb).
REQ-016 Decimation ratio R = number of ock_p between consecutive uck_p; R is not programmed, and steady-state |y3| = R^3 for a constant input.
REQ-017 Scaling: s = y3 << shift, computed at 64 bits, then saturated to the 32-bit signed range [0x80000000, 0x7FFFFFFF].
REQ-018 Output coding: signed_data=1 gives dout = s; signed_data=0 gives dout = s XOR 0x80000000.
REQ-019 State machine: FILL -> RUN. FILL counts uck_p with a 2-bit counter and moves to RUN on the 3rd uck_p. RUN is held until reset.
REQ-020 dout and dout_vld SHALL register 1 clk after the uck_p cycle and only in RUN; in FILL, dout holds and dout_vld stays 0.
REQ-021 A uck_p with zero ock_p since the previous uck_p SHALL still be processed, giving a zero difference.
REQ-022 signed_data and shift SHALL be sampled on the uck_p cycle; a change between uck_p events has no effect on dout.

Reset
REQ-023 On rstn low, SHALL clear the synchronizers, integrators, comb delays, FILL counter, dout (0x00000000) and dout_vld (0), and enter FILL, all without waiting for clk.
REQ-024 Reset mid-run SHALL discard all history; after release, the block needs 3 uck_p again before the first dout_vld.

Configuration
REQ-025 Macro PDM_CIC_RX_OVF_EN defined: SHALL add output port ovf (1 bit) plus an 9-bit ock_p counter cleared on uck_p; ovf sets sticky when the count exceeds 256 (R > 256, where the 32-bit CIC growth is no longer guaranteed) and clears only on reset.
REQ-026 Macro PDM_CIC_RX_OVF_EN undefined: SHALL have no ovf port and no counter; behaviour is otherwise identical.

Structure
REQ-027 Shared package pdm_pkg SHALL hold CIC_ORDER=3, ACC_W=32, RMAX=256, typedef acc_t (signed [ACC_W-1:0]), and the FILL/RUN state enum.
REQ-028 Sub-module pdm_edge_sync SHALL implement the 2-flop sync plus rising-edge pulse, instantiated for ock and uck.

Verification
REQ-029 sdi=1 constant, R=16, shift=7, signed_data=1 -> after fill, every dout = 0x00080000 (4096<<7), with dout_vld once per uck.
REQ-030 sdi=0 constant, R=16, shift=7 -> signed_data=1 gives 0xFFF80000; signed_data=0 gives 0x7FF80000.
REQ-031 sdi alternating 1/0, R=16, shift=7, signed_data=0 -> steady dout = 0x80000000.
REQ-032 sdi=1, R=256, shift=7, signed_data=1 -> y3 = 2^24 saturates, so dout = 0x7FFFFFFF; with shift=6, dout = 0x40000000.
REQ-033 rstn pulsed low mid-RUN -> dout = 0 and dout_vld = 0 immediately; no dout_vld until the 3rd uck_p after release.
REQ-034 PDM_CIC_RX_OVF_EN defined, 300 ock edges in one uck period -> ovf = 1 and stays 1 at R=16 until rstn.
